vending_ctrl: RTL

VENDING_CTRL -- requirements
Module: vending_ctrl

---
 rtl/vending_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vending_ctrl.sv
// rtl/vending_ctrl.sv - coin-operated vending FSM with greedy change return
// Optional COLLECT inactivity auto-cancel enabled by defining VEND_TIMEOUT_EN.
module vending_ctrl #(
    parameter int PRICE       = 30,
    parameter int N_PROD      = 4,
    parameter int CREDIT_W    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      coin_valid,
    input  logic [1:0]                coin,
    input  logic                      cancel,
    input  logic                      sel_valid,
    input  logic [$clog2(N_PROD)-1:0] sel,
    input  logic [N_PROD-1:0]         stock,
    output logic                      vend_valid,
    output logic [$clog2(N_PROD)-1:0] vend_id,
    output logic                      chg_valid,
    output logic [1:0]                chg_coin,
    output logic                      coin_rej,
    output logic                      sel_err,
    output logic [CREDIT_W-1:0]       credit,
    output logic                      busy
);
    localparam int                  SEL_W      = $clog2(N_PROD);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                vend_valid_q;
    logic [SEL_W-1:0]    vend_id_q;
    logic                chg_valid_q;
    logic [1:0]          chg_coin_q;
    logic                coin_rej_q;
    logic                sel_err_q;
    logic                busy_q;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return CREDIT_W'(5);
            2'b10:   return CREDIT_W'(10);
            2'b11:   return CREDIT_W'(25);
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] change_code(input logic [CREDIT_W-1:0] amount);
        if (amount >= CREDIT_W'(25))      return 2'b11;
        else if (amount >= CREDIT_W'(10)) return 2'b10;
        else if (amount >= CREDIT_W'(5))  return 2'b01;
        else                              return 2'b00;
    endfunction

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_new;
    logic                stock_hit;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vend_rem;
    logic [CREDIT_W-1:0] chg_src;
    logic [1:0]          chg_code;
    logic [CREDIT_W-1:0] chg_rem;
    logic                timeout;

    // A coin arriving alongside cancel/select is folded into credit before either acts.
    always_comb begin
        coin_sum   = {1'b0, credit_q} + {1'b0, coin_value(coin)};
        coin_ok    = coin_valid && (coin != 2'b00) && (coin_sum <= CREDIT_MAX) &&
                     ((state_q == IDLE) || (state_q == COLLECT));
        credit_new = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
        stock_hit  = (int'(sel) < N_PROD) ? stock[sel] : 1'b0;
        sel_ok     = stock_hit && (credit_new >= PRICE_C);
        vend_rem   = credit_new - PRICE_C;
        chg_src    = (state_q == COLLECT) ? credit_new : credit_q;
        chg_code   = change_code(chg_src);
        chg_rem    = chg_src - coin_value(chg_code);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;

    assign timeout = (state_q == COLLECT) && !coin_ok && !sel_valid &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || (state_q != COLLECT) || coin_ok || sel_valid || timeout) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            vend_valid_q <= 1'b0;
            vend_id_q    <= '0;
            chg_valid_q  <= 1'b0;
            chg_coin_q   <= 2'b00;
            coin_rej_q   <= 1'b0;
            sel_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vend_valid_q <= 1'b0;
            chg_valid_q  <= 1'b0;
            sel_err_q    <= 1'b0;
            coin_rej_q   <= coin_valid && !coin_ok;
            case (state_q)
                IDLE: begin
                    if (coin_ok) begin
                        credit_q <= credit_new;
                        state_q  <= COLLECT;
                    end
                end
                COLLECT: begin
                    credit_q <= credit_new;
                    if ((cancel || timeout) && (credit_new != '0)) begin
                        state_q     <= CHANGE;
                        busy_q      <= 1'b1;
                        chg_valid_q <= 1'b1;
                        chg_coin_q  <= chg_code;
                        credit_q    <= chg_rem;
                    end else if (sel_valid) begin
                        if (sel_ok) begin
                            state_q      <= VEND;
                            busy_q       <= 1'b1;
                            vend_valid_q <= 1'b1;
                            vend_id_q    <= sel;
                            credit_q     <= vend_rem;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                VEND, CHANGE: begin
                    // Each cycle here pays out one coin until the credit is exhausted.
                    if (credit_q != '0) begin
                        state_q     <= CHANGE;
                        chg_valid_q <= 1'b1;
                        chg_coin_q  <= chg_code;
                        credit_q    <= chg_rem;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vend_valid = vend_valid_q;
    assign vend_id    = vend_id_q;
    assign chg_valid  = chg_valid_q;
    assign chg_coin   = chg_coin_q;
    assign coin_rej   = coin_rej_q;
    assign sel_err    = sel_err_q;
    assign credit     = credit_q;
    assign busy       = busy_q;

endmodule
